// File: rtl/jesd204b_reg_pkg.sv
// Shared constants for the JESD204B link register bank: register map,
// field layout and reset defaults of the double-buffered link configuration.
package jesd204b_reg_pkg;

  localparam int REG_ID       = 0;
  localparam int REG_CTRL     = 1;
  localparam int REG_CFG0     = 2;
  localparam int REG_CFG1     = 3;
  localparam int REG_STATUS   = 4;
  localparam int REG_IRQ_MASK = 5;
  localparam int REG_ACTIVE0  = 6;
  localparam int REG_ERR_CNT  = 7;

  localparam int CTRL_LINK_EN_BIT = 0;
  localparam int CTRL_COMMIT_BIT  = 1;

  localparam int STATUS_W = 8;
  localparam int ERRCNT_W = 16;

  localparam logic [15:0] ID_DEFAULT = 16'h2040;

  // Field order mirrors the CFG0/CFG1 register layouts.
  typedef struct packed {
    logic [7:0] ilas_mf;
    logic       scr_en;
    logic [3:0] l;
    logic [4:0] k;
    logic [4:0] f;
  } link_cfg_t;

  localparam link_cfg_t CFG_RESET = '{ilas_mf: 8'd3, scr_en: 1'b0, l: 4'd0, k: 5'd31, f: 5'd0};

  function automatic logic [15:0] cfg0_word(input link_cfg_t c);
    return {2'b00, c.l, c.k, c.f};
  endfunction

  function automatic logic [15:0] cfg1_word(input link_cfg_t c);
    return {c.ilas_mf, 7'b0, c.scr_en};
  endfunction

endpackage

// File: rtl/jesd204b_sticky_w1c.sv
// N-bit sticky status vector: bits set by event pulses, cleared by writing 1.
// A set in the same cycle as a clear wins, so no event is ever lost.
module jesd204b_sticky_w1c #(
  parameter int N = 8
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic [N-1:0] i_set,
  input  logic [N-1:0] i_clr,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_q <= '0;
    else          r_q <= (r_q & ~i_clr) | i_set;
  end

  assign o_q = r_q;

endmodule

// File: rtl/jesd204b_link_regbank.sv
// JESD204B link register bank: shadow/active link config applied on LMFC edge,
// W1C status with masked irq. Optional error counter under JESD_REG_ERRCNT_EN.
module jesd204b_link_regbank
  import jesd204b_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic [STATUS_W-1:0]   i_status_evt,
  input  logic                  i_err_pulse,
  input  logic                  i_lmfc_edge,
  output logic                  o_link_en,
  output logic [4:0]            o_cfg_f,
  output logic [4:0]            o_cfg_k,
  output logic [3:0]            o_cfg_l,
  output logic                  o_scr_en,
  output logic [7:0]            o_ilas_mf,
  output logic                  o_cfg_update,
  output logic                  o_irq
);

  logic                r_link_en;
  logic                r_commit_pend;
  link_cfg_t           r_shadow;
  link_cfg_t           r_active;
  logic                r_cfg_update;
  logic [STATUS_W-1:0] r_irq_mask;
  logic                r_irq;

  logic                w_wr_ctrl, w_wr_cfg0, w_wr_cfg1, w_wr_status, w_wr_mask, w_wr_errcnt;
  logic                w_apply;
  logic [STATUS_W-1:0] w_status;
  logic [STATUS_W-1:0] w_status_clr;
  logic [ERRCNT_W-1:0] w_err_cnt;
  logic [15:0]         w_rdata16;

  assign w_wr_ctrl   = i_wr && (i_addr == ADDR_WIDTH'(REG_CTRL));
  assign w_wr_cfg0   = i_wr && (i_addr == ADDR_WIDTH'(REG_CFG0));
  assign w_wr_cfg1   = i_wr && (i_addr == ADDR_WIDTH'(REG_CFG1));
  assign w_wr_status = i_wr && (i_addr == ADDR_WIDTH'(REG_STATUS));
  assign w_wr_mask   = i_wr && (i_addr == ADDR_WIDTH'(REG_IRQ_MASK));
  assign w_wr_errcnt = i_wr && (i_addr == ADDR_WIDTH'(REG_ERR_CNT));

  // With the link down there is no LMFC to wait for, so a commit applies at once.
  assign w_apply = r_commit_pend && (i_lmfc_edge || !r_link_en);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_link_en     <= 1'b0;
      r_commit_pend <= 1'b0;
      r_shadow      <= CFG_RESET;
      r_active      <= CFG_RESET;
      r_cfg_update  <= 1'b0;
      r_irq_mask    <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_link_en <= i_wdata[CTRL_LINK_EN_BIT];

      // A fresh commit request outranks the apply that would retire the old one.
      if (w_wr_ctrl && i_wdata[CTRL_COMMIT_BIT]) r_commit_pend <= 1'b1;
      else if (w_apply)                          r_commit_pend <= 1'b0;

      if (w_wr_cfg0) begin
        r_shadow.l <= i_wdata[13:10];
        r_shadow.k <= i_wdata[9:5];
        r_shadow.f <= i_wdata[4:0];
      end
      if (w_wr_cfg1) begin
        r_shadow.ilas_mf <= i_wdata[15:8];
        r_shadow.scr_en  <= i_wdata[0];
      end

      if (w_apply) r_active <= r_shadow;
      r_cfg_update <= w_apply;

      if (w_wr_mask) r_irq_mask <= i_wdata[STATUS_W-1:0];
      r_irq <= |(w_status & r_irq_mask);
    end
  end

  assign w_status_clr = w_wr_status ? i_wdata[STATUS_W-1:0] : '0;

  jesd204b_sticky_w1c #(.N(STATUS_W)) u_status (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_set   (i_status_evt),
    .i_clr   (w_status_clr),
    .o_q     (w_status)
  );

`ifdef JESD_REG_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                   r_err_cnt <= '0;
    else if (w_wr_errcnt)           r_err_cnt <= ERRCNT_W'(i_err_pulse);
    else if (i_err_pulse && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign w_err_cnt = r_err_cnt;
`else
  logic w_unused_err;

  assign w_unused_err = i_err_pulse ^ w_wr_errcnt;
  assign w_err_cnt    = '0;
`endif

  // NOTE: default assigned before the case so no path leaves w_rdata16 unassigned (no latch).
  always_comb begin
    w_rdata16 = '0;
    case (i_addr)
      ADDR_WIDTH'(REG_ID):       w_rdata16 = ID_VALUE;
      ADDR_WIDTH'(REG_CTRL):     w_rdata16 = {14'b0, r_commit_pend, r_link_en};
      ADDR_WIDTH'(REG_CFG0):     w_rdata16 = cfg0_word(r_shadow);
      ADDR_WIDTH'(REG_CFG1):     w_rdata16 = cfg1_word(r_shadow);
      ADDR_WIDTH'(REG_STATUS):   w_rdata16 = {8'b0, w_status};
      ADDR_WIDTH'(REG_IRQ_MASK): w_rdata16 = {8'b0, r_irq_mask};
      ADDR_WIDTH'(REG_ACTIVE0):  w_rdata16 = cfg0_word(r_active);
      ADDR_WIDTH'(REG_ERR_CNT):  w_rdata16 = w_err_cnt;
      default:                   w_rdata16 = '0;
    endcase
  end

  assign o_rdata      = DATA_WIDTH'(w_rdata16);
  assign o_link_en    = r_link_en;
  assign o_cfg_f      = r_active.f;
  assign o_cfg_k      = r_active.k;
  assign o_cfg_l      = r_active.l;
  assign o_scr_en     = r_active.scr_en;
  assign o_ilas_mf    = r_active.ilas_mf;
  assign o_cfg_update = r_cfg_update;
  assign o_irq        = r_irq;

endmodule

// File: tb/tb_jesd204b_link_regbank.sv
// Directed self-checking bench for jesd204b_link_regbank; inputs change and
// outputs are sampled on the falling edge of PCLK.
module tb_jesd204b_link_regbank;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic        i_wr;
  logic [15:0] o_rdata;
  logic [7:0]  i_status_evt;
  logic        i_err_pulse;
  logic        i_lmfc_edge;
  logic        o_link_en;
  logic [4:0]  o_cfg_f;
  logic [4:0]  o_cfg_k;
  logic [3:0]  o_cfg_l;
  logic        o_scr_en;
  logic [7:0]  o_ilas_mf;
  logic        o_cfg_update;
  logic        o_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  jesd204b_link_regbank dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_wr         (i_wr),
    .o_rdata      (o_rdata),
    .i_status_evt (i_status_evt),
    .i_err_pulse  (i_err_pulse),
    .i_lmfc_edge  (i_lmfc_edge),
    .o_link_en    (o_link_en),
    .o_cfg_f      (o_cfg_f),
    .o_cfg_k      (o_cfg_k),
    .o_cfg_l      (o_cfg_l),
    .o_scr_en     (o_scr_en),
    .o_ilas_mf    (o_ilas_mf),
    .o_cfg_update (o_cfg_update),
    .o_irq        (o_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
  endtask

  // One-cycle write; returns on the falling edge after the write edge.
  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    i_addr  = a;
    i_wdata = d;
    i_wr    = 1'b1;
    step();
    i_wr    = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string tag);
    i_addr = a;
    #1;
    check(tag, o_rdata, exp);
  endtask

  task automatic count_updates(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (o_cfg_update) n++;
      step();
    end
  endtask

  logic [15:0] rst_map [8] = '{16'h2040, 16'h0000, 16'h03E0, 16'h0300,
                               16'h0000, 16'h0000, 16'h03E0, 16'h0000};
  int n_upd;

  initial begin
    PRESETn      = 1'b0;
    i_addr       = '0;
    i_wdata      = '0;
    i_wr         = 1'b0;
    i_status_evt = '0;
    i_err_pulse  = 1'b0;
    i_lmfc_edge  = 1'b0;
    repeat (3) step();
    PRESETn = 1'b1;
    step();

    // Reset state
    for (int a = 0; a < 8; a++) rd_chk(16'(a), rst_map[a], $sformatf("rst_rd%0d", a));
    rd_chk(16'd9, 16'h0000, "unmapped_rd");
    check("rst_irq", o_irq, 1'b0);
    check("rst_link_en", o_link_en, 1'b0);
    check("rst_cfg_k", o_cfg_k, 5'd31);
    check("rst_ilas", o_ilas_mf, 8'd3);

    // Unmapped write ignored
    wr_reg(16'd9, 16'hFFFF);
    rd_chk(16'd9, 16'h0000, "unmapped_wr");

    // Immediate apply with link down
    wr_reg(16'd2, 16'h0C43);
    wr_reg(16'd3, 16'h0501);
    rd_chk(16'd3, 16'h0501, "cfg1_rd");
    rd_chk(16'd6, 16'h03E0, "active_before_commit");
    wr_reg(16'd1, 16'h0002);
    count_updates(6, n_upd);
    check("upd_once", n_upd, 1);
    rd_chk(16'd6, 16'h0C43, "active_after_commit");
    rd_chk(16'd1, 16'h0000, "ctrl_after_commit");
    check("cfg_f", o_cfg_f, 5'd3);
    check("cfg_k", o_cfg_k, 5'd2);
    check("cfg_l", o_cfg_l, 4'd3);
    check("scr_en", o_scr_en, 1'b1);
    check("ilas_mf", o_ilas_mf, 8'd5);

    // Link up: apply waits for the LMFC edge
    wr_reg(16'd2, 16'h0421);
    wr_reg(16'd1, 16'h0003);
    repeat (3) step();
    rd_chk(16'd6, 16'h0C43, "active_held");
    rd_chk(16'd1, 16'h0003, "ctrl_pend");
    check("no_upd_wait", o_cfg_update, 1'b0);
    check("link_en_up", o_link_en, 1'b1);
    i_lmfc_edge = 1'b1;
    step();
    i_lmfc_edge = 1'b0;
    rd_chk(16'd6, 16'h0421, "active_lmfc");
    rd_chk(16'd1, 16'h0001, "ctrl_lmfc");
    check("upd_lmfc", o_cfg_update, 1'b1);
    step();
    check("upd_pulse_end", o_cfg_update, 1'b0);

    // Apply coincident with a shadow write takes the old shadow
    wr_reg(16'd1, 16'h0003);
    i_lmfc_edge = 1'b1;
    wr_reg(16'd2, 16'h0862);
    i_lmfc_edge = 1'b0;
    rd_chk(16'd6, 16'h0421, "apply_pre_write");
    rd_chk(16'd2, 16'h0862, "shadow_new");
    rd_chk(16'd1, 16'h0001, "ctrl_after_race");

    // Apply coincident with a commit write keeps commit pending
    wr_reg(16'd1, 16'h0003);
    i_lmfc_edge = 1'b1;
    wr_reg(16'd1, 16'h0003);
    i_lmfc_edge = 1'b0;
    rd_chk(16'd6, 16'h0862, "apply_with_commit");
    rd_chk(16'd1, 16'h0003, "commit_kept");
    i_lmfc_edge = 1'b1;
    step();
    i_lmfc_edge = 1'b0;
    rd_chk(16'd1, 16'h0001, "commit_retired");

    // Status, mask and irq
    i_status_evt = 8'h04;
    step();
    i_status_evt = 8'h00;
    rd_chk(16'd4, 16'h0004, "status_set");
    check("irq_masked", o_irq, 1'b0);
    wr_reg(16'd5, 16'h0004);
    rd_chk(16'd5, 16'h0004, "mask_rd");
    step();
    check("irq_on", o_irq, 1'b1);
    i_status_evt = 8'h04;
    wr_reg(16'd4, 16'h0004);
    i_status_evt = 8'h00;
    rd_chk(16'd4, 16'h0004, "set_beats_clr");
    wr_reg(16'd4, 16'h0004);
    rd_chk(16'd4, 16'h0000, "status_clr");
    check("irq_lag", o_irq, 1'b1);
    step();
    check("irq_off", o_irq, 1'b0);

    // Reset in the middle of a pending commit
    wr_reg(16'd5, 16'h0001);
    i_status_evt = 8'h01;
    step();
    i_status_evt = 8'h00;
    wr_reg(16'd2, 16'h0C43);
    wr_reg(16'd1, 16'h0003);
    step();
    check("pre_rst_irq", o_irq, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_link_en", o_link_en, 1'b0);
    check("mid_rst_irq", o_irq, 1'b0);
    check("mid_rst_upd", o_cfg_update, 1'b0);
    check("mid_rst_active", {o_cfg_l, o_cfg_k, o_cfg_f}, {4'd0, 5'd31, 5'd0});
    check("mid_rst_scr_ilas", {o_scr_en, o_ilas_mf}, {1'b0, 8'd3});
    rd_chk(16'd1, 16'h0000, "mid_rst_ctrl");
    rd_chk(16'd2, 16'h03E0, "mid_rst_shadow");
    step();
    PRESETn = 1'b1;
    i_lmfc_edge = 1'b1;
    step();
    i_lmfc_edge = 1'b0;
    count_updates(5, n_upd);
    check("no_upd_after_rst", n_upd, 0);
    rd_chk(16'd6, 16'h03E0, "active_after_rst");

    // Error counter
    for (int p = 0; p < 3; p++) begin
      i_err_pulse = 1'b1;
      step();
      i_err_pulse = 1'b0;
      step();
    end
`ifdef JESD_REG_ERRCNT_EN
    rd_chk(16'd7, 16'h0003, "errcnt_3");
    i_err_pulse = 1'b1;
    wr_reg(16'd7, 16'h0007);
    i_err_pulse = 1'b0;
    rd_chk(16'd7, 16'h0001, "errcnt_clr_pulse");
    wr_reg(16'd7, 16'h0000);
    rd_chk(16'd7, 16'h0000, "errcnt_clr");
    i_err_pulse = 1'b1;
    repeat (65540) step();
    i_err_pulse = 1'b0;
    rd_chk(16'd7, 16'hFFFF, "errcnt_sat");
`else
    rd_chk(16'd7, 16'h0000, "errcnt_absent");
    i_err_pulse = 1'b1;
    wr_reg(16'd7, 16'h0007);
    i_err_pulse = 1'b0;
    rd_chk(16'd7, 16'h0000, "errcnt_absent_wr");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
